// File: rtl/n64_ctrl_nav_decoder.sv
// n64_ctrl_nav_decoder
//   Turns N64 controller poll words from the sniffer into one-cycle OSD
//   navigation events (with debounce-by-poll and auto-repeat on directions),
//   a held-combo event and a controller-present flag.
//
// Ports
//   CLK_4M        in   1   sole clock
//   RST           in   1   synchronous, active-high reset
//   ctrl_data     in  32   poll word (buttons in [15:0], stick X/Y in [31:16])
//   ctrl_valid    in   1   one-cycle strobe qualifying ctrl_data
//   nav_evt       out  6   one-cycle pulses {back, enter, right, left, down, up}
//   combo_evt     out  1   one-cycle pulse when COMBO held for COMBO_POLLS polls
//   ctrl_present  out  1   high while polls keep arriving within TIMEOUT_CYC
//
// Decoded button vector (the bit positions COMBO refers to):
//   0 A, 1 B, 2 Z, 3 St, 4 L, 5 R, 6 JoyRst, 7 reserved raw bit 9,
//   8 Du, 9 Dd, 10 Dl, 11 Dr, 12 Cu, 13 Cd, 14 Cl, 15 Cr
//
// Optional feature macro: CTRL_STICK_NAV_EN -- when defined, analog stick
// deflection beyond STICK_THR also drives the four directions.
module n64_ctrl_nav_decoder #(
  parameter logic [5:0]  REP_DELAY   = 6'd20,
  parameter logic [5:0]  REP_RATE    = 6'd5,
  parameter logic [7:0]  STICK_THR   = 8'd40,
  parameter logic [19:0] TIMEOUT_CYC = 20'd200000,
  parameter logic [15:0] COMBO       = 16'h0034,
  parameter logic [5:0]  COMBO_POLLS = 6'd30
) (
  input  logic        CLK_4M,
  input  logic        RST,
  input  logic [31:0] ctrl_data,
  input  logic        ctrl_valid,
  output logic [5:0]  nav_evt,
  output logic        combo_evt,
  output logic        ctrl_present
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DELAY = 2'd1, ST_REPEAT = 2'd2} state_t;
  typedef enum logic [2:0] {DIR_NONE = 3'd0, DIR_UP = 3'd1, DIR_DOWN = 3'd2,
                            DIR_LEFT = 3'd3, DIR_RIGHT = 3'd4} dir_t;

  // A zero delay/rate would never expire a down-counter; clamp to one poll.
  localparam logic [5:0] DELAY_EFF = (REP_DELAY == 6'd0) ? 6'd1 : REP_DELAY;
  localparam logic [5:0] RATE_EFF  = (REP_RATE == 6'd0) ? 6'd1 : REP_RATE;

  function automatic logic [3:0] dir_pulse(input dir_t d);
    case (d)
      DIR_UP:    dir_pulse = 4'b0001;
      DIR_DOWN:  dir_pulse = 4'b0010;
      DIR_LEFT:  dir_pulse = 4'b0100;
      DIR_RIGHT: dir_pulse = 4'b1000;
      default:   dir_pulse = 4'b0000;
    endcase
  endfunction

  logic [15:0] btn_s;
  logic        stk_up_s, stk_down_s, stk_left_s, stk_right_s;
  logic        up_s, down_s, left_s, right_s, enter_s, back_s, combo_hit_s;
  dir_t        dir_s;

  state_t      state_q, state_d;
  dir_t        dir_q, dir_d;
  logic [5:0]  rcnt_q, rcnt_d;
  logic [5:0]  ccnt_q, ccnt_d;
  logic [19:0] wd_q, wd_d;
  logic        prev_enter_q, prev_enter_d;
  logic        prev_back_q, prev_back_d;
  logic [5:0]  nav_q, nav_d;
  logic        combo_q, combo_d;
  logic        present_q, present_d;

  assign btn_s = {ctrl_data[15:12], ctrl_data[7:4], ctrl_data[9], ctrl_data[8],
                  ctrl_data[11], ctrl_data[10], ctrl_data[3:0]};

`ifdef CTRL_STICK_NAV_EN
  localparam logic signed [8:0] THR_POS = $signed({1'b0, STICK_THR});
  localparam logic signed [8:0] THR_NEG = -THR_POS;

  logic signed [8:0] stick_x_s, stick_y_s;

  // Stick bytes arrive MSB at the lowest bit index; reverse and sign-extend.
  always_comb begin
    stick_x_s = 9'sd0;
    stick_y_s = 9'sd0;
    for (int i = 0; i < 8; i++) begin
      stick_x_s[7-i] = ctrl_data[16+i];
      stick_y_s[7-i] = ctrl_data[24+i];
    end
    stick_x_s[8] = stick_x_s[7];
    stick_y_s[8] = stick_y_s[7];
  end

  // Stick thresholds; a JoyRst poll carries a recentring stick, so ignore it.
  always_comb begin
    if (ctrl_data[8]) begin
      stk_up_s    = 1'b0;
      stk_down_s  = 1'b0;
      stk_left_s  = 1'b0;
      stk_right_s = 1'b0;
    end else begin
      stk_up_s    = (stick_y_s >= THR_POS);
      stk_down_s  = (stick_y_s <= THR_NEG);
      stk_left_s  = (stick_x_s <= THR_NEG);
      stk_right_s = (stick_x_s >= THR_POS);
    end
  end
`else
  logic unused_stick_s;
  assign unused_stick_s = ^{ctrl_data[31:16], STICK_THR};
  assign stk_up_s    = 1'b0;
  assign stk_down_s  = 1'b0;
  assign stk_left_s  = 1'b0;
  assign stk_right_s = 1'b0;
`endif

  assign up_s        = btn_s[8]  | btn_s[12] | stk_up_s;
  assign down_s      = btn_s[9]  | btn_s[13] | stk_down_s;
  assign left_s      = btn_s[10] | btn_s[14] | stk_left_s;
  assign right_s     = btn_s[11] | btn_s[15] | stk_right_s;
  assign enter_s     = btn_s[0] | btn_s[3];
  assign back_s      = btn_s[1];
  assign combo_hit_s = ((btn_s & COMBO) == COMBO);

  // Direction selection with fixed priority UP > DOWN > LEFT > RIGHT.
  always_comb begin
    if (up_s) begin
      dir_s = DIR_UP;
    end else if (down_s) begin
      dir_s = DIR_DOWN;
    end else if (left_s) begin
      dir_s = DIR_LEFT;
    end else if (right_s) begin
      dir_s = DIR_RIGHT;
    end else begin
      dir_s = DIR_NONE;
    end
  end

  // Next-state logic: poll decode, repeat FSM, combo counter and watchdog.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    rcnt_d       = rcnt_q;
    ccnt_d       = ccnt_q;
    wd_d         = wd_q;
    prev_enter_d = prev_enter_q;
    prev_back_d  = prev_back_q;
    nav_d        = 6'b000000;
    combo_d      = 1'b0;
    present_d    = present_q;
    if (ctrl_valid) begin
      // A valid poll always beats a watchdog expiry in the same cycle.
      wd_d         = 20'd0;
      present_d    = 1'b1;
      nav_d[4]     = enter_s & ~prev_enter_q;
      nav_d[5]     = back_s & ~prev_back_q;
      prev_enter_d = enter_s;
      prev_back_d  = back_s;
      if (combo_hit_s) begin
        if (ccnt_q != COMBO_POLLS) begin
          ccnt_d  = ccnt_q + 6'd1;
          combo_d = ((ccnt_q + 6'd1) == COMBO_POLLS);
        end else begin
          ccnt_d = ccnt_q;
        end
      end else begin
        ccnt_d = 6'd0;
      end
      case (state_q)
        ST_IDLE: begin
          if (dir_s != DIR_NONE) begin
            nav_d[3:0] = dir_pulse(dir_s);
            dir_d      = dir_s;
            rcnt_d     = DELAY_EFF;
            state_d    = ST_DELAY;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (dir_s == DIR_NONE) begin
            state_d = ST_IDLE;
            dir_d   = DIR_NONE;
            rcnt_d  = 6'd0;
          end else if (dir_s != dir_q) begin
            nav_d[3:0] = dir_pulse(dir_s);
            dir_d      = dir_s;
            rcnt_d     = DELAY_EFF;
            state_d    = ST_DELAY;
          end else if (rcnt_q <= 6'd1) begin
            // Counter reaches zero on this poll; reload rather than wrap.
            nav_d[3:0] = dir_pulse(dir_q);
            rcnt_d     = RATE_EFF;
            state_d    = ST_REPEAT;
          end else begin
            rcnt_d = rcnt_q - 6'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          dir_d   = DIR_NONE;
          rcnt_d  = 6'd0;
        end
      endcase
    end else if (({1'b0, wd_q} + 21'd1) >= {1'b0, TIMEOUT_CYC}) begin
      // Controller absent: drop all history so held buttons re-fire later.
      wd_d         = TIMEOUT_CYC;
      present_d    = 1'b0;
      state_d      = ST_IDLE;
      dir_d        = DIR_NONE;
      rcnt_d       = 6'd0;
      ccnt_d       = 6'd0;
      prev_enter_d = 1'b0;
      prev_back_d  = 1'b0;
    end else begin
      wd_d = wd_q + 20'd1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK_4M) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      dir_q        <= DIR_NONE;
      rcnt_q       <= 6'd0;
      ccnt_q       <= 6'd0;
      wd_q         <= 20'd0;
      prev_enter_q <= 1'b0;
      prev_back_q  <= 1'b0;
      nav_q        <= 6'b000000;
      combo_q      <= 1'b0;
      present_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      rcnt_q       <= rcnt_d;
      ccnt_q       <= ccnt_d;
      wd_q         <= wd_d;
      prev_enter_q <= prev_enter_d;
      prev_back_q  <= prev_back_d;
      nav_q        <= nav_d;
      combo_q      <= combo_d;
      present_q    <= present_d;
    end
  end

  assign nav_evt      = nav_q;
  assign combo_evt    = combo_q;
  assign ctrl_present = present_q;

endmodule

// File: tb/tb_n64_ctrl_nav_decoder.sv
// Self-checking bench for n64_ctrl_nav_decoder. The reference model tracks
// how long the current direction has been held and how long the combo has
// run, and derives the expected events from those hold lengths. The
// watchdog timeout is shortened so the run stays short.
module tb_n64_ctrl_nav_decoder;

  localparam int T_CYC = 500;
  localparam int DLY   = 20;
  localparam int RATE  = 5;
  localparam int CPOLL = 30;
  localparam int THR   = 40;

  logic        CLK_4M = 1'b0;
  logic        RST;
  logic [31:0] ctrl_data;
  logic        ctrl_valid;
  logic [5:0]  nav_evt;
  logic        combo_evt;
  logic        ctrl_present;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_dir, m_hold, m_run, m_idle;
  bit m_prev_enter, m_prev_back, m_present;

  always #5 CLK_4M = ~CLK_4M;

  n64_ctrl_nav_decoder #(.TIMEOUT_CYC(20'd500)) dut (
    .CLK_4M(CLK_4M), .RST(RST), .ctrl_data(ctrl_data), .ctrl_valid(ctrl_valid),
    .nav_evt(nav_evt), .combo_evt(combo_evt), .ctrl_present(ctrl_present)
  );

  function automatic int stick_of(input logic [31:0] d, input int base);
    int v = 0;
    for (int i = 0; i < 8; i++) v = v * 2 + int'(d[base + i]);
    if (v > 127) v = v - 256;
    return v;
  endfunction

  function automatic logic [31:0] with_stick(input logic [31:0] d, input int x, input int y);
    logic [31:0] r;
    logic [7:0]  xb, yb;
    r  = d;
    xb = x[7:0];
    yb = y[7:0];
    for (int i = 0; i < 8; i++) begin
      r[16 + i] = xb[7 - i];
      r[24 + i] = yb[7 - i];
    end
    return r;
  endfunction

  function automatic int model_dir(input logic [31:0] d);
    bit up, dn, lf, rt;
    up = d[4] | d[12];
    dn = d[5] | d[13];
    lf = d[6] | d[14];
    rt = d[7] | d[15];
`ifdef CTRL_STICK_NAV_EN
    if (!d[8]) begin
      if (stick_of(d, 24) >= THR)  up = 1'b1;
      if (stick_of(d, 24) <= -THR) dn = 1'b1;
      if (stick_of(d, 16) >= THR)  rt = 1'b1;
      if (stick_of(d, 16) <= -THR) lf = 1'b1;
    end
`endif
    if (up) return 1;
    if (dn) return 2;
    if (lf) return 3;
    if (rt) return 4;
    return 0;
  endfunction

  task automatic model_clear();
    m_dir = 0; m_hold = 0; m_run = 0; m_prev_enter = 1'b0; m_prev_back = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    m_present = 1'b0;
    m_idle    = 0;
  endtask

  task automatic model_poll(input logic [31:0] d, output logic [5:0] en, output logic ec);
    int  dir;
    bit  fire, ent, bk;
    if (m_idle >= T_CYC) model_clear();
    m_idle    = 0;
    m_present = 1'b1;
    en  = 6'b0;
    dir = model_dir(d);
    if (dir == 0) m_hold = 0;
    else if (dir == m_dir) m_hold++;
    else m_hold = 1;
    m_dir = dir;
    fire = (dir != 0) && ((m_hold == 1) ||
           ((m_hold >= 1 + DLY) && ((m_hold - 1 - DLY) % RATE == 0)));
    if (fire) en[dir - 1] = 1'b1;
    ent = d[0] | d[3];
    bk  = d[1];
    en[4] = ent & !m_prev_enter;
    en[5] = bk & !m_prev_back;
    m_prev_enter = ent;
    m_prev_back  = bk;
    m_run = (d[2] & d[10] & d[11]) ? m_run + 1 : 0;
    ec = (m_run == CPOLL);
  endtask

  task automatic send_poll(input logic [31:0] d, output logic [5:0] on,
                           output logic oc, output logic op);
    ctrl_data  = d;
    ctrl_valid = 1'b1;
    @(posedge CLK_4M);
    @(negedge CLK_4M);
    on = nav_evt;
    oc = combo_evt;
    op = ctrl_present;
    ctrl_valid = 1'b0;
  endtask

  task automatic idle(input int n, output bit stray, output logic pres);
    stray = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK_4M);
      @(negedge CLK_4M);
      if (nav_evt !== 6'b0 || combo_evt !== 1'b0) stray = 1'b1;
    end
    pres   = ctrl_present;
    m_idle = m_idle + n;
  endtask

  task automatic test_reset();
    logic [5:0] on, en;
    logic oc, op, ec;
    RST = 1'b1; ctrl_valid = 1'b0; ctrl_data = 32'h0;
    repeat (3) @(negedge CLK_4M);
    RST = 1'b0;
    model_reset();
    n_checks++; if (nav_evt !== 6'b0) begin n_fail++; $display("FAIL reset_nav: got %b expected 000000", nav_evt); end
    n_checks++; if (combo_evt !== 1'b0) begin n_fail++; $display("FAIL reset_combo: got %b expected 0", combo_evt); end
    n_checks++; if (ctrl_present !== 1'b0) begin n_fail++; $display("FAIL reset_present: got %b expected 0", ctrl_present); end
    for (int p = 1; p <= 5; p++) begin
      send_poll(32'h0, on, oc, op);
      model_poll(32'h0, en, ec);
      n_checks++; if (on !== en || oc !== ec) begin n_fail++; $display("FAIL reset_poll%0d: got %b/%b expected %b/%b", p, on, oc, en, ec); end
      n_checks++; if (op !== 1'b1) begin n_fail++; $display("FAIL reset_present_poll%0d: got %b expected 1", p, op); end
    end
  endtask

  task automatic test_repeat();
    logic [5:0] on, en;
    logic oc, op, ec;
    int pulses = 0;
    for (int p = 1; p <= 30; p++) begin
      send_poll(32'h10, on, oc, op);
      model_poll(32'h10, en, ec);
      if (on == 6'b000001) pulses++;
      n_checks++; if (on !== en || oc !== ec) begin n_fail++; $display("FAIL repeat_poll%0d: got %b/%b expected %b/%b", p, on, oc, en, ec); end
    end
    n_checks++; if (pulses != 3) begin n_fail++; $display("FAIL repeat_count: got %0d expected 3", pulses); end
    send_poll(32'h0, on, oc, op);
    model_poll(32'h0, en, ec);
    n_checks++; if (on !== en) begin n_fail++; $display("FAIL repeat_release: got %b expected %b", on, en); end
  endtask

  task automatic test_dir_change();
    logic [5:0] on, en;
    logic oc, op, ec;
    logic [31:0] d;
    for (int p = 1; p <= 23; p++) begin
      d = (p == 1) ? 32'h30 : ((p == 23) ? 32'h0 : 32'h20);
      send_poll(d, on, oc, op);
      model_poll(d, en, ec);
      n_checks++; if (on !== en) begin n_fail++; $display("FAIL dirchg_poll%0d: got %b expected %b", p, on, en); end
      if (p == 1) begin
        n_checks++; if (on !== 6'b000001) begin n_fail++; $display("FAIL dirchg_up_first: got %b expected 000001", on); end
      end else if (p == 2 || p == 22) begin
        n_checks++; if (on !== 6'b000010) begin n_fail++; $display("FAIL dirchg_down_poll%0d: got %b expected 000010", p, on); end
      end
    end
  endtask

  task automatic test_enter_combo();
    logic [5:0] on, en;
    logic oc, op, ec;
    int enters = 0, combos = 0, combo_at = 0;
    for (int p = 1; p <= 41; p++) begin
      send_poll((p <= 40) ? 32'h1 : 32'h0, on, oc, op);
      model_poll((p <= 40) ? 32'h1 : 32'h0, en, ec);
      if (on[4]) enters++;
      n_checks++; if (on !== en) begin n_fail++; $display("FAIL enter_poll%0d: got %b expected %b", p, on, en); end
    end
    n_checks++; if (enters != 1) begin n_fail++; $display("FAIL enter_count: got %0d expected 1", enters); end
    for (int p = 1; p <= 35; p++) begin
      send_poll(32'h0C04, on, oc, op);
      model_poll(32'h0C04, en, ec);
      if (oc) begin combos++; combo_at = p; end
      n_checks++; if (oc !== ec || on !== en) begin n_fail++; $display("FAIL combo_poll%0d: got %b/%b expected %b/%b", p, on, oc, en, ec); end
    end
    n_checks++; if (combos != 1 || combo_at != 30) begin n_fail++; $display("FAIL combo_once: got %0d pulses at %0d expected 1 at 30", combos, combo_at); end
    send_poll(32'h0, on, oc, op);
    model_poll(32'h0, en, ec);
  endtask

  task automatic test_timeout();
    logic [5:0] on, en;
    logic oc, op, ec, pres;
    bit stray;
    for (int p = 1; p <= 5; p++) begin
      send_poll(32'h10, on, oc, op);
      model_poll(32'h10, en, ec);
      n_checks++; if (on !== en) begin n_fail++; $display("FAIL timeout_pre%0d: got %b expected %b", p, on, en); end
    end
    // Poll arrives exactly when the watchdog would expire: poll wins.
    idle(T_CYC - 1, stray, pres);
    n_checks++; if (stray || pres !== 1'b1) begin n_fail++; $display("FAIL timeout_edge_idle: got stray=%0d present=%b expected 0/1", stray, pres); end
    send_poll(32'h10, on, oc, op);
    model_poll(32'h10, en, ec);
    n_checks++; if (op !== 1'b1 || on !== en) begin n_fail++; $display("FAIL timeout_valid_wins: got %b/%b expected 1/%b", op, on, en); end
    idle(T_CYC + 3, stray, pres);
    n_checks++; if (stray || pres !== 1'b0) begin n_fail++; $display("FAIL timeout_absent: got stray=%0d present=%b expected 0/0", stray, pres); end
    send_poll(32'h10, on, oc, op);
    model_poll(32'h10, en, ec);
    n_checks++; if (on !== 6'b000001 || on !== en || op !== 1'b1) begin n_fail++; $display("FAIL timeout_recover: got %b/%b expected %b/1", on, op, en); end
    send_poll(32'h0, on, oc, op);
    model_poll(32'h0, en, ec);
  endtask

  task automatic test_midreset();
    logic [5:0] on, en;
    logic oc, op, ec, pres;
    bit stray;
    for (int p = 1; p <= 20; p++) begin
      send_poll(32'h40, on, oc, op);
      model_poll(32'h40, en, ec);
      n_checks++; if (on !== en) begin n_fail++; $display("FAIL midrst_poll%0d: got %b expected %b", p, on, en); end
    end
    // Reset lands on the poll that would have repeated; that poll is ignored.
    RST = 1'b1; ctrl_data = 32'h41; ctrl_valid = 1'b1;
    @(posedge CLK_4M);
    @(negedge CLK_4M);
    n_checks++; if (nav_evt !== 6'b0 || combo_evt !== 1'b0 || ctrl_present !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs: got %b/%b/%b expected 000000/0/0", nav_evt, combo_evt, ctrl_present); end
    RST = 1'b0; ctrl_valid = 1'b0;
    model_reset();
    idle(3, stray, pres);
    n_checks++; if (stray || pres !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got stray=%0d present=%b expected 0/0", stray, pres); end
    send_poll(32'h40, on, oc, op);
    model_poll(32'h40, en, ec);
    n_checks++; if (on !== en || on !== 6'b000100) begin n_fail++; $display("FAIL midrst_after: got %b expected %b", on, en); end
  endtask

  task automatic test_stick();
    logic [5:0] on, en;
    logic oc, op, ec;
    logic [31:0] d;
    for (int k = 0; k < 8; k++) begin
      case (k)
        0: d = with_stick(32'h0, 40, 0);
        1: d = with_stick(32'h0, 39, 0);
        2: d = with_stick(32'h100, 40, 0);
        3: d = with_stick(32'h0, 127, 0);
        4: d = with_stick(32'h0, -40, 0);
        5: d = with_stick(32'h0, 0, -40);
        6: d = with_stick(32'h0, 0, 40);
        default: d = with_stick(32'h0, -39, -39);
      endcase
      send_poll(d, on, oc, op);
      model_poll(d, en, ec);
      n_checks++; if (on !== en) begin n_fail++; $display("FAIL stick_case%0d: got %b expected %b", k, on, en); end
`ifdef CTRL_STICK_NAV_EN
      if (k == 0) begin
        n_checks++; if (on !== 6'b001000) begin n_fail++; $display("FAIL stick_x40: got %b expected 001000", on); end
      end
`else
      if (k == 3) begin
        n_checks++; if (on !== 6'b000000) begin n_fail++; $display("FAIL stick_ignored: got %b expected 000000", on); end
      end
`endif
      send_poll(32'h0, on, oc, op);
      model_poll(32'h0, en, ec);
    end
  endtask

  task automatic test_random();
    logic [5:0] on, en;
    logic oc, op, ec, pres;
    logic [31:0] cur;
    logic [15:0] b;
    bit stray;
    int gap;
    cur = 32'h0;
    for (int p = 0; p < 400; p++) begin
      if ($urandom_range(0, 9) >= 7) begin
        b = 16'($urandom_range(0, 65535) & $urandom_range(0, 65535) & $urandom_range(0, 65535));
        if ($urandom_range(0, 3) == 0) b = b | 16'h0C04;
        cur = with_stick({16'h0, b}, int'($urandom_range(0, 100)) - 50,
                         int'($urandom_range(0, 100)) - 50);
      end
      gap = int'($urandom_range(0, 3));
      idle(gap, stray, pres);
      n_checks++; if (stray) begin n_fail++; $display("FAIL random_stray%0d: got pulse in gap expected none", p); end
      send_poll(cur, on, oc, op);
      model_poll(cur, en, ec);
      n_checks++; if (on !== en || oc !== ec || op !== 1'b1) begin n_fail++; $display("FAIL random_poll%0d data=%h: got %b/%b/%b expected %b/%b/1", p, cur, on, oc, op, en, ec); end
    end
  endtask

  initial begin
    RST = 1'b1;
    ctrl_valid = 1'b0;
    ctrl_data = 32'h0;
    model_reset();
    @(negedge CLK_4M);
    test_reset();
    test_repeat();
    test_dir_change();
    test_enter_combo();
    test_timeout();
    test_midreset();
    test_stick();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
